hidden_layer_seq: RTL and testbench
===================================

HIDDEN_LAYER_SEQ -- requirements
Module: hidden_layer_seq

Interface
REQ-001 Parameter N_NEURONS, default 8, is the number of hidden neurons time-multiplexed onto one neuron datapath (1..256).
REQ-002 Parameter PIPE_LAT, default 6, is the cycles from x/w presented at the datapath to y valid (1..31).
REQ-003 Parameter AW, default 8, is the weight/result address width, with 2^AW >= N_NEURONS.
REQ-004 clk  input  1  single clock; all logic is rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle layer start request.
REQ-007 x_in  input  136  concatenated 8x17-bit layer inputs, sampled on an accepted start.
REQ-008 w_addr  output  AW  weight ROM address; the neuron index.
REQ-009 w_data  input  136  weight ROM data, valid one cycle after w_addr.
REQ-010 n_ce  output  1  datapath clock enable.
REQ-011 n_x  output  136  datapath input vector.
REQ-012 n_w  output  136  datapath weight vector.
REQ-013 n_y  input  17  datapath activation output.
REQ-014 y_we  output  1  result write strobe.
REQ-015 y_addr  output  AW  result neuron index.
REQ-016 y_data  output  17  result value.
REQ-017 busy  output  1  high from an accepted start until done.
REQ-018 done  output  1  one-cycle pulse after the last result write.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, DRAIN and FINISH.
REQ-020 In IDLE, start=1 SHALL latch x_in into an internal register, clear the issue counter, and go to ISSUE the next cycle.
REQ-021 Start SHALL be ignored in any state other than IDLE.
REQ-022 In ISSUE, w_addr SHALL equal the issue counter, and the counter SHALL increment every cycle.
REQ-023 ISSUE SHALL go to DRAIN after address N_NEURONS-1 has been issued.
REQ-024 n_w SHALL be w_data passed through combinationally, and n_x SHALL be the latched x register.
REQ-025 Each issued index SHALL enter a valid/index tag shift register of depth 1+PIPE_LAT.
REQ-026 When a valid tag exits the shift register, y_we=1, y_addr=tag index, and y_data=n_y in that same cycle.
REQ-027 Result k SHALL therefore appear exactly k+1+PIPE_LAT cycles after the first ISSUE cycle.
REQ-028 Results SHALL be written once each, in ascending index order.
REQ-029 DRAIN SHALL go to FINISH in the cycle after the write of index N_NEURONS-1.
REQ-030 FINISH SHALL assert done for one cycle and then return to IDLE.
REQ-031 busy SHALL be 1 in ISSUE and DRAIN, and 0 in IDLE and FINISH.
REQ-032 n_ce SHALL be 1 whenever busy=1, and 0 otherwise.
REQ-033 With N_NEURONS=1, the FSM SHALL spend one cycle in ISSUE, and the timing in REQ-027 SHALL still hold.
REQ-034 The issue counter SHALL be AW+1 bits wide, so terminal detection does not wrap.
REQ-035 A start in the same cycle as done, or while in FINISH, SHALL be ignored.

Reset
REQ-036 On rst_n=0, the FSM SHALL go to IDLE asynchronously, and the counter, x register and tag shift register SHALL be cleared.
REQ-037 During reset, y_we=0, y_addr=0, y_data=0, w_addr=0, n_ce=0, busy=0, done=0 and n_x=0.
REQ-038 A reset during ISSUE or DRAIN SHALL discard every in-flight result, with no y_we after rst_n is released.
REQ-039 After reset is released, the block SHALL accept a start on the first clock edge.

Configuration
REQ-040 With macro HIDDEN_LAYER_SEQ_ABORT_EN defined, an extra input abort (1 bit) SHALL exist.
REQ-041 With the macro defined, abort=1 in ISSUE or DRAIN SHALL clear all tag valid bits and go to IDLE on the next edge.
REQ-042 An abort SHALL produce no done pulse and no further y_we.
REQ-043 Abort SHALL have priority over a simultaneous result write, so the write in that cycle is suppressed.
REQ-044 Without the macro, the abort port SHALL NOT exist, and the behaviour is as in REQ-019..REQ-035.

Verification
REQ-045 Default parameters, start with x_in=0, ROM[k]=k, n_y model = index delayed by PIPE_LAT -> y_we at cycles 8..15 after start, with y_addr=y_data=0..7 in order, done at cycle 16, busy for cycles 1..15.
REQ-046 N_NEURONS=1, PIPE_LAT=1, start -> a single y_we at cycle 3 with y_addr=0, and done at cycle 4.
REQ-047 Start pulses at cycles 3, 5 and 16 of a run, then start again in FINISH -> each of these is ignored, exactly 8 writes occur, and no second run begins.
REQ-048 rst_n asserted at cycle 10 of a run and released at cycle 12 -> outputs are 0 immediately on assertion, and no y_we or done follows.
REQ-049 ABORT_EN defined, abort at cycle 9 -> only index 0 is written, with no done, busy=0 at cycle 10, and a new start completes normally.
REQ-050 Back-to-back runs with start on the cycle after done -> the second run's timing is identical to the first.

Source files
------------

// File: rtl/hidden_layer_seq.sv
// Sequences one shared neuron datapath over N_NEURONS hidden neurons.
// Ports: start/x_in in, w_addr/w_data ROM, n_* datapath, y_* results, busy/done; opt. abort (HIDDEN_LAYER_SEQ_ABORT_EN).
module hidden_layer_seq #(
  parameter int N_NEURONS = 8,
  parameter int PIPE_LAT  = 6,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
`ifdef HIDDEN_LAYER_SEQ_ABORT_EN
  input  logic          abort,
`endif
  input  logic [135:0]  x_in,
  output logic [AW-1:0] w_addr,
  input  logic [135:0]  w_data,
  output logic          n_ce,
  output logic [135:0]  n_x,
  output logic [135:0]  n_w,
  input  logic [16:0]   n_y,
  output logic          y_we,
  output logic [AW-1:0] y_addr,
  output logic [16:0]   y_data,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } state_t;

  localparam int DEPTH = 1 + PIPE_LAT;

  state_t         state;
  logic [AW:0]    cnt;
  logic [135:0]   x_q;
  logic [DEPTH-1:0] tag_v;
  logic [AW-1:0]  tag_i [DEPTH];
  logic           abort_hit;
  logic           last_issue;
  logic           last_wr;

`ifdef HIDDEN_LAYER_SEQ_ABORT_EN
  assign abort_hit = abort & busy;
`else
  assign abort_hit = 1'b0;
`endif

  assign busy       = (state == ISSUE) || (state == DRAIN);
  assign done       = (state == FINISH);
  assign n_ce       = busy;
  assign n_x        = x_q;
  assign n_w        = w_data;
  assign w_addr     = (state == ISSUE) ? cnt[AW-1:0] : '0;

  // Abort wins over a result leaving the tag pipe in the same cycle.
  assign y_we       = tag_v[DEPTH-1] & ~abort_hit;
  assign y_addr     = y_we ? tag_i[DEPTH-1] : '0;
  assign y_data     = y_we ? n_y : '0;

  assign last_issue = (cnt == (AW+1)'(N_NEURONS - 1));
  assign last_wr    = y_we && (tag_i[DEPTH-1] == AW'(N_NEURONS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      x_q   <= '0;
      tag_v <= '0;
      for (int i = 0; i < DEPTH; i++) tag_i[i] <= '0;
    end else begin
      tag_v    <= {tag_v[DEPTH-2:0], state == ISSUE};
      tag_i[0] <= cnt[AW-1:0];
      for (int i = 1; i < DEPTH; i++) tag_i[i] <= tag_i[i-1];
      unique case (state)
        IDLE: begin
          if (start) begin
            x_q   <= x_in;
            cnt   <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= cnt + 1'b1;
          if (last_issue) state <= DRAIN;
        end
        DRAIN: begin
          if (last_wr) state <= FINISH;
        end
        FINISH: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (abort_hit) begin
        state <= IDLE;
        tag_v <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hidden_layer_seq.sv
// Directed bench for hidden_layer_seq: default build plus an N=1/LAT=1 instance.
// Datapath model: y = w[16:0] + x[16:0], PIPE_LAT cycles after presentation.
module tb_hidden_layer_seq;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          start1 = 1'b0;
  logic [135:0]  x_in = '0;
`ifdef HIDDEN_LAYER_SEQ_ABORT_EN
  logic          abort = 1'b0;
`endif

  logic [7:0]    w_addr;
  logic [135:0]  w_data = '0;
  logic          n_ce;
  logic [135:0]  n_x;
  logic [135:0]  n_w;
  logic [16:0]   n_y;
  logic          y_we;
  logic [7:0]    y_addr;
  logic [16:0]   y_data;
  logic          busy;
  logic          done;

  logic [0:0]    w_addr1;
  logic [135:0]  w_data1 = '0;
  logic          n_ce1;
  logic [135:0]  n_x1;
  logic [135:0]  n_w1;
  logic [16:0]   n_y1 = '0;
  logic          y_we1;
  logic [0:0]    y_addr1;
  logic [16:0]   y_data1;
  logic          busy1;
  logic          done1;

  logic [16:0]   pipe [6];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  hidden_layer_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef HIDDEN_LAYER_SEQ_ABORT_EN
    .abort(abort),
`endif
    .x_in(x_in), .w_addr(w_addr), .w_data(w_data),
    .n_ce(n_ce), .n_x(n_x), .n_w(n_w), .n_y(n_y),
    .y_we(y_we), .y_addr(y_addr), .y_data(y_data),
    .busy(busy), .done(done)
  );

  hidden_layer_seq #(.N_NEURONS(1), .PIPE_LAT(1), .AW(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef HIDDEN_LAYER_SEQ_ABORT_EN
    .abort(1'b0),
`endif
    .x_in(x_in), .w_addr(w_addr1), .w_data(w_data1),
    .n_ce(n_ce1), .n_x(n_x1), .n_w(n_w1), .n_y(n_y1),
    .y_we(y_we1), .y_addr(y_addr1), .y_data(y_data1),
    .busy(busy1), .done(done1)
  );

  // ROM[k] = k, one-cycle read; datapath model pipes.
  always @(posedge clk) begin
    w_data  <= {128'd0, w_addr};
    w_data1 <= {135'd0, w_addr1};
    pipe[0] <= n_w[16:0] + n_x[16:0];
    for (int i = 1; i < 6; i++) pipe[i] <= pipe[i-1];
    n_y1    <= n_w1[16:0] + n_x1[16:0];
  end
  assign n_y = pipe[5];

  always @(negedge clk) begin
    #2;
    if (y_we === 1'b1) wr_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  typedef struct packed {
    logic       st;
    logic       bz;
    logic       we;
    logic [7:0] ad;
    logic       dn;
    logic [7:0] wa;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic st, bz, we,
                              input logic [7:0] ad,
                              input logic dn,
                              input logic [7:0] wa);
    vec_t v;
    v.st = st; v.bz = bz; v.we = we;
    v.ad = ad; v.dn = dn; v.wa = wa;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Applies one run from the table; call at a negedge.
  task automatic run_tbl(input logic [16:0] xv, input logic extra);
    for (int c = 0; c < 17; c++) begin
      start = tbl[c].st | (extra && (c == 3 || c == 5 || c == 16));
      x_in  = (c == 0) ? {8{xv}} : '1;
      #1;
      chk($sformatf("busy c%0d", c), 32'(busy), 32'(tbl[c].bz));
      chk($sformatf("n_ce c%0d", c), 32'(n_ce), 32'(tbl[c].bz));
      chk($sformatf("y_we c%0d", c), 32'(y_we), 32'(tbl[c].we));
      chk($sformatf("done c%0d", c), 32'(done), 32'(tbl[c].dn));
      chk($sformatf("w_addr c%0d", c), 32'(w_addr), 32'(tbl[c].wa));
      if (tbl[c].we) begin
        chk($sformatf("y_addr c%0d", c), 32'(y_addr), 32'(tbl[c].ad));
        chk($sformatf("y_data c%0d", c), 32'(y_data),
            32'(17'(tbl[c].ad) + xv));
      end
      if (tbl[c].bz)
        chk($sformatf("n_x c%0d", c), 32'(n_x[16:0]), 32'(xv));
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  int w0, d0;

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 1);
    tbl[3]  = mk(0, 1, 0, 0, 0, 2);
    tbl[4]  = mk(0, 1, 0, 0, 0, 3);
    tbl[5]  = mk(0, 1, 0, 0, 0, 4);
    tbl[6]  = mk(0, 1, 0, 0, 0, 5);
    tbl[7]  = mk(0, 1, 0, 0, 0, 6);
    tbl[8]  = mk(0, 1, 1, 0, 0, 7);
    tbl[9]  = mk(0, 1, 1, 1, 0, 0);
    tbl[10] = mk(0, 1, 1, 2, 0, 0);
    tbl[11] = mk(0, 1, 1, 3, 0, 0);
    tbl[12] = mk(0, 1, 1, 4, 0, 0);
    tbl[13] = mk(0, 1, 1, 5, 0, 0);
    tbl[14] = mk(0, 1, 1, 6, 0, 0);
    tbl[15] = mk(0, 1, 1, 7, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 1, 0);

    // Reset state
    @(negedge clk);
    #1;
    chk("rst y_we", 32'(y_we), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst n_ce", 32'(n_ce), 0);
    chk("rst w_addr", 32'(w_addr), 0);
    chk("rst n_x", 32'(n_x[31:0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic run, then back-to-back runs with new x
    run_tbl(17'd0, 1'b0);
    w0 = wr_cnt;
    run_tbl(17'd100, 1'b0);
    chk("b2b writes", 32'(wr_cnt - w0), 8);

    // Stray starts in ISSUE, DRAIN, FINISH are ignored
    w0 = wr_cnt;
    d0 = done_cnt;
    run_tbl(17'd7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("idle busy %0d", i), 32'(busy), 0);
      @(negedge clk);
    end
    chk("stray writes", 32'(wr_cnt - w0), 8);
    chk("stray done", 32'(done_cnt - d0), 1);

    // Single neuron, one-cycle latency
    start1 = 1'b1;
    x_in   = {8{17'd5}};
    @(negedge clk);
    start1 = 1'b0;
    x_in   = '0;
    #1;
    chk("n1 busy c1", 32'(busy1), 1);
    chk("n1 y_we c1", 32'(y_we1), 0);
    @(negedge clk); #1;
    chk("n1 y_we c2", 32'(y_we1), 0);
    @(negedge clk); #1;
    chk("n1 y_we c3", 32'(y_we1), 1);
    chk("n1 y_addr c3", 32'(y_addr1), 0);
    chk("n1 y_data c3", 32'(y_data1), 5);
    chk("n1 done c3", 32'(done1), 0);
    @(negedge clk); #1;
    chk("n1 done c4", 32'(done1), 1);
    chk("n1 busy c4", 32'(busy1), 0);
    chk("n1 y_we c4", 32'(y_we1), 0);
    @(negedge clk); #1;
    chk("n1 done c5", 32'(done1), 0);
    @(negedge clk);

    // Reset in the middle of DRAIN
    start = 1'b1;
    x_in  = {8{17'h1234}};
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    chk("pre-rst y_we", 32'(y_we), 1);
    rst_n = 1'b0;
    #1;
    chk("mid-rst y_we", 32'(y_we), 0);
    chk("mid-rst y_addr", 32'(y_addr), 0);
    chk("mid-rst y_data", 32'(y_data), 0);
    chk("mid-rst w_addr", 32'(w_addr), 0);
    chk("mid-rst n_ce", 32'(n_ce), 0);
    chk("mid-rst busy", 32'(busy), 0);
    chk("mid-rst done", 32'(done), 0);
    chk("mid-rst n_x", 32'(n_x[31:0]), 0);
    w0 = wr_cnt;
    d0 = done_cnt;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post-rst writes", 32'(wr_cnt - w0), 0);
    chk("post-rst done", 32'(done_cnt - d0), 0);

    // Start accepted on the first edge after release
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("first-edge busy", 32'(busy), 1);
    repeat (15) @(negedge clk);
    #1;
    chk("first-edge done", 32'(done), 1);
    @(negedge clk);

`ifdef HIDDEN_LAYER_SEQ_ABORT_EN
    // Abort at cycle 9 suppresses index 1 and returns to IDLE
    w0 = wr_cnt;
    d0 = done_cnt;
    start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    abort = 1'b1;
    #1;
    chk("abort y_we", 32'(y_we), 0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 0);
    chk("abort writes", 32'(wr_cnt - w0), 1);
    repeat (20) @(negedge clk);
    chk("abort late writes", 32'(wr_cnt - w0), 1);
    chk("abort done", 32'(done_cnt - d0), 0);
    run_tbl(17'd3, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
